// File: rtl/tick_seq_ctrl.sv
// Run-control sequencer for the decade tick counter: programmable prescaler,
// 0..DIGIT_MAX digit, start/pause/stop control and a valid/ready period port.
module tick_seq_ctrl #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned DEFAULT_MAX = 25000000,
  parameter int unsigned DIGIT_MAX   = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic             stop,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_max,
  output logic             cfg_ready,
  output logic             tick,
  output logic [3:0]       digit,
  output logic             wrap,
  output logic [1:0]       state,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LOAD  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  state_e             ret_q, ret_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic [CNT_W-1:0]   presc_q, presc_d;
  logic [3:0]         digit_q, digit_d;
  logic               tick_q, tick_d;
  logic               wrap_q, wrap_d;
  logic               busy_q, busy_d;
  logic               cfg_ready_q, cfg_ready_d;
  logic               hs;

  // cfg_ready_q is high exactly in IDLE/PAUSE, so it doubles as the accept gate
  assign hs = cfg_valid & cfg_ready_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ret_q       <= IDLE;
      period_q    <= CNT_W'(DEFAULT_MAX);
      presc_q     <= '0;
      digit_q     <= '0;
      tick_q      <= 1'b0;
      wrap_q      <= 1'b0;
      busy_q      <= 1'b0;
      cfg_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      period_q    <= period_d;
      presc_q     <= presc_d;
      digit_q     <= digit_d;
      tick_q      <= tick_d;
      wrap_q      <= wrap_d;
      busy_q      <= busy_d;
      cfg_ready_q <= cfg_ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    if (stop) begin
      state_d = IDLE;
    end else if (hs) begin
      state_d = LOAD;
      ret_d   = state_q;
    end else begin
      unique case (state_q)
        IDLE:    if (start) state_d = RUN;
        RUN:     if (pause) state_d = PAUSE;
        PAUSE:   if (start && !pause) state_d = RUN;
        LOAD:    state_d = ret_q;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    presc_d  = presc_q;
    digit_d  = digit_q;
    period_d = period_q;
    tick_d   = 1'b0;
    wrap_d   = 1'b0;
    if (stop) begin
      presc_d = '0;
      digit_d = '0;
    end else if (hs) begin
      period_d = (cfg_max == '0) ? CNT_W'(1) : cfg_max;
    end else begin
      unique case (state_q)
        IDLE: presc_d = '0;
        // the pause cycle itself still counts, so an expiry here is not lost
        RUN: begin
          if (presc_q == period_q) begin
            presc_d = '0;
            tick_d  = 1'b1;
            if (digit_q == 4'(DIGIT_MAX)) begin
              digit_d = '0;
              wrap_d  = 1'b1;
            end else begin
              digit_d = digit_q + 4'd1;
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        LOAD:    presc_d = '0;
        default: ;
      endcase
    end
    busy_d      = (state_d == RUN);
    cfg_ready_d = (state_d == IDLE) || (state_d == PAUSE);
  end

  assign state     = state_q;
  assign busy      = busy_q;
  assign cfg_ready = cfg_ready_q;
  assign tick      = tick_q;
  assign wrap      = wrap_q;
  assign digit     = digit_q;

endmodule
